// File: rtl/mont_mul_word.sv
// mont_mul_word: word-serial Montgomery multiplier, result = a*b*2^-WIDTH mod n.
// Build option MONT_FINAL_SUB_EN: final conditional subtraction (result < n); otherwise result < 2n.
module mont_mul_word #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned WORD  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic [WORD-1:0]  n0prime,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             done
);
    localparam int unsigned NW = WIDTH / WORD;
    localparam int unsigned TW = WIDTH + WORD + 2;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned RW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ACC, RED, FINAL} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n, n_q, n_n;
    logic [WORD-1:0]  n0p_q, n0p_n, m;
    logic [TW-1:0]    t_q, t_n, t_sum;
    logic [IW-1:0]    i_q, i_n;
    logic [RW-1:0]    result_n;
    logic             busy_n, done_n;

    // Next-state and datapath; a_q is shifted down one word per RED so its low word is always a[i].
    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        n_n      = n_q;
        n0p_n    = n0p_q;
        t_n      = t_q;
        i_n      = i_q;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;
        m        = t_q[WORD-1:0] * n0p_q;
        t_sum    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    n_n     = n;
                    n0p_n   = n0prime;
                    t_n     = '0;
                    i_n     = '0;
                    busy_n  = 1'b1;
                    state_n = ACC;
                end
            end
            ACC: begin
                t_n     = t_q + TW'(a_q[WORD-1:0]) * TW'(b_q);
                state_n = RED;
            end
            RED: begin
                // Adding m*n clears the low word, so the shift is exact.
                t_sum   = t_q + TW'(m) * TW'(n_q);
                t_n     = t_sum >> WORD;
                a_n     = a_q >> WORD;
                i_n     = i_q + IW'(1);
                state_n = (i_q == IW'(NW - 1)) ? FINAL : ACC;
            end
            FINAL: begin
`ifdef MONT_FINAL_SUB_EN
                result_n = (t_q >= TW'(n_q)) ? RW'(t_q - TW'(n_q)) : RW'(t_q);
`else
                result_n = RW'(t_q);
`endif
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            n0p_q  <= '0;
            t_q    <= '0;
            i_q    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            a_q    <= a_n;
            b_q    <= b_n;
            n_q    <= n_n;
            n0p_q  <= n0p_n;
            t_q    <= t_n;
            i_q    <= i_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule
